// File: rtl/sr_2_jk.sv
// -----------------------------------------------------------------------------
// sr_2_jk
//   WIDTH-bit JK flip-flop bank built from SR flip-flop cores. Each bit's SR
//   core is driven through JK conversion logic:
//     s = j & ~q
//     r = k &  q
//   This gives the JK table (hold / clear / set / toggle) with one clock of
//   latency. A sticky error flag watches every SR core for the forbidden
//   s=r=1 input, which the conversion logic should never produce.
//
// Parameters
//   WIDTH   number of JK bits (>=1)
//   CNT_W   width of the toggle-event counter (used only with SR2JK_TCNT_EN)
//
// Ports
//   clk      in   1      clock, all state updates on posedge
//   rst      in   1      synchronous active-high reset, priority over en
//   en       in   1      clock enable, 0 holds all state
//   j        in   WIDTH  per-bit J input
//   k        in   WIDTH  per-bit K input
//   q        out  WIDTH  registered flip-flop state
//   qb       out  WIDTH  always ~q
//   toggled  out  WIDTH  per-bit pulse: that bit of q changed on the last edge
//   sr_err   out  1      sticky, set when any SR core saw s=r=1
//   tcnt     out  CNT_W  saturating count of edges on which any bit changed
//
// Configuration macro
//   SR2JK_TCNT_EN  defined: tcnt port and counter exist
//                  undefined: no tcnt port, no counter logic
// -----------------------------------------------------------------------------
module sr_2_jk #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] toggled,
`ifdef SR2JK_TCNT_EN
  output logic             sr_err,
  output logic [CNT_W-1:0] tcnt
`else
  output logic             sr_err
`endif
);

  logic [WIDTH-1:0] q_p0;
  logic [WIDTH-1:0] toggled_p0;
  logic             sr_err_p0;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_change;
  logic             sr_conflict;

  // ---- stage 0: JK-to-SR conversion and SR core next state ----
  assign s = j & ~q_p0;
  assign r = k & q_p0;

  always_comb begin
    q_next      = q_p0;
    sr_conflict = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b00:   q_next[i] = q_p0[i];
        // Forbidden SR input: the core holds and the error flag is raised.
        default: begin
          q_next[i]   = q_p0[i];
          sr_conflict = 1'b1;
        end
      endcase
    end
  end

  assign q_change = q_next ^ q_p0;

  // ---- stage 0 -> registered state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p0       <= '0;
      toggled_p0 <= '0;
      sr_err_p0  <= 1'b0;
    end else begin
      // The change pulse is dropped on disabled cycles rather than held.
      toggled_p0 <= en ? q_change : '0;
      if (en) begin
        q_p0 <= q_next;
        if (sr_conflict) begin
          sr_err_p0 <= 1'b1;
        end
      end
    end
  end

`ifdef SR2JK_TCNT_EN
  logic [CNT_W-1:0] tcnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_p0 <= '0;
    end else if (en && (|q_change)) begin
      tcnt_p0 <= sat_inc(tcnt_p0);
    end
  end

  assign tcnt = tcnt_p0;
`endif

  assign q       = q_p0;
  assign qb      = ~q_p0;
  assign toggled = toggled_p0;
  assign sr_err  = sr_err_p0;

endmodule

// File: tb/tb_sr_2_jk.sv
module tb_sr_2_jk;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic [3:0] qb;
  logic [3:0] toggled;
  logic       sr_err;

  int checks;
  int errors;

`ifdef SR2JK_TCNT_EN
  logic [7:0] tcnt;
  logic       rst2;
  logic       en2;
  logic [3:0] j2;
  logic [3:0] k2;
  logic [3:0] q2;
  logic [3:0] qb2;
  logic [3:0] toggled2;
  logic       sr_err2;
  logic [1:0] tcnt2;
`endif

  sr_2_jk #(.WIDTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .j       (j),
    .k       (k),
    .q       (q),
    .qb      (qb),
    .toggled (toggled),
`ifdef SR2JK_TCNT_EN
    .sr_err  (sr_err),
    .tcnt    (tcnt)
`else
    .sr_err  (sr_err)
`endif
  );

`ifdef SR2JK_TCNT_EN
  sr_2_jk #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk     (clk),
    .rst     (rst2),
    .en      (en2),
    .j       (j2),
    .k       (k2),
    .q       (q2),
    .qb      (qb2),
    .toggled (toggled2),
    .sr_err  (sr_err2),
    .tcnt    (tcnt2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; j = 4'b1111; k = 4'b0000;
    step();
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b want %b", q, 4'b0000); end
    checks++;
    if (qb !== 4'b1111) begin errors++; $display("FAIL reset_qb got %b want %b", qb, 4'b1111); end
    checks++;
    if (toggled !== 4'b0000) begin errors++; $display("FAIL reset_toggled got %b want %b", toggled, 4'b0000); end
    checks++;
    if (sr_err !== 1'b0) begin errors++; $display("FAIL reset_sr_err got %b want %b", sr_err, 1'b0); end
`ifdef SR2JK_TCNT_EN
    checks++;
    if (tcnt !== 8'd0) begin errors++; $display("FAIL reset_tcnt got %0d want %0d", tcnt, 0); end
`endif
    rst = 1'b0; en = 1'b1; j = 4'b0000; k = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (q !== 4'b0000 || qb !== 4'b1111 || toggled !== 4'b0000 || sr_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold edge %0d got q=%b qb=%b tg=%b err=%b want q=0000 qb=1111 tg=0000 err=0",
                 n, q, qb, toggled, sr_err);
      end
    end
  endtask

  task automatic test_glitch();
    // j/k pulse between edges must leave q alone.
    #2 j = 4'b1111; k = 4'b1111;
    #2 j = 4'b0000; k = 4'b0000;
    step();
    checks++;
    if (q !== 4'b0000 || toggled !== 4'b0000) begin
      errors++;
      $display("FAIL glitch got q=%b tg=%b want q=0000 tg=0000", q, toggled);
    end
  endtask

  task automatic test_set_clear();
    j = 4'b1010; k = 4'b0000;
    step();
    checks++;
    if (q !== 4'b1010 || qb !== 4'b0101 || toggled !== 4'b1010) begin
      errors++;
      $display("FAIL set got q=%b qb=%b tg=%b want q=1010 qb=0101 tg=1010", q, qb, toggled);
    end
    j = 4'b0000; k = 4'b1000;
    step();
    checks++;
    if (q !== 4'b0010 || qb !== 4'b1101 || toggled !== 4'b1000) begin
      errors++;
      $display("FAIL clear got q=%b qb=%b tg=%b want q=0010 qb=1101 tg=1000", q, qb, toggled);
    end
`ifdef SR2JK_TCNT_EN
    checks++;
    if (tcnt !== 8'd2) begin errors++; $display("FAIL set_clear_tcnt got %0d want %0d", tcnt, 2); end
`endif
  endtask

  task automatic test_toggle();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b1101; exp_q[1] = 4'b0010; exp_q[2] = 4'b1101;
    j = 4'b1111; k = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (q !== exp_q[n] || toggled !== 4'b1111 || sr_err !== 1'b0) begin
        errors++;
        $display("FAIL toggle edge %0d got q=%b tg=%b err=%b want q=%b tg=1111 err=0",
                 n, q, toggled, sr_err, exp_q[n]);
      end
    end
`ifdef SR2JK_TCNT_EN
    checks++;
    if (tcnt !== 8'd5) begin errors++; $display("FAIL toggle_tcnt got %0d want %0d", tcnt, 5); end
`endif
  endtask

  task automatic test_enable_hold();
    en = 1'b0; j = 4'b1111; k = 4'b1111;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if (q !== 4'b1101 || qb !== 4'b0010 || toggled !== 4'b0000) begin
        errors++;
        $display("FAIL en_hold edge %0d got q=%b qb=%b tg=%b want q=1101 qb=0010 tg=0000",
                 n, q, qb, toggled);
      end
    end
`ifdef SR2JK_TCNT_EN
    checks++;
    if (tcnt !== 8'd5) begin errors++; $display("FAIL en_hold_tcnt got %0d want %0d", tcnt, 5); end
`endif
  endtask

  task automatic test_mixed();
    // From 1101: bit3 clear, bit2 set (already 1), bit1 toggle, bit0 hold.
    en = 1'b1; j = 4'b0110; k = 4'b1010;
    step();
    checks++;
    if (q !== 4'b0111 || toggled !== 4'b1010 || sr_err !== 1'b0) begin
      errors++;
      $display("FAIL mixed got q=%b tg=%b err=%b want q=0111 tg=1010 err=0", q, toggled, sr_err);
    end
`ifdef SR2JK_TCNT_EN
    checks++;
    if (tcnt !== 8'd6) begin errors++; $display("FAIL mixed_tcnt got %0d want %0d", tcnt, 6); end
`endif
  endtask

  task automatic test_reset_mid();
    en = 1'b1; j = 4'b1111; k = 4'b1111;
    step();
    checks++;
    if (q !== 4'b1000 || toggled !== 4'b1111) begin
      errors++;
      $display("FAIL pre_rst_toggle got q=%b tg=%b want q=1000 tg=1111", q, toggled);
    end
    rst = 1'b1;
    step();
    checks++;
    if (q !== 4'b0000 || qb !== 4'b1111 || toggled !== 4'b0000 || sr_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got q=%b qb=%b tg=%b err=%b want q=0000 qb=1111 tg=0000 err=0",
               q, qb, toggled, sr_err);
    end
`ifdef SR2JK_TCNT_EN
    checks++;
    if (tcnt !== 8'd0) begin errors++; $display("FAIL mid_rst_tcnt got %0d want %0d", tcnt, 0); end
`endif
    // Reset also wins over a disabled cycle with a pending set.
    rst = 1'b0; en = 1'b1; j = 4'b0101; k = 4'b0000;
    step();
    rst = 1'b1; en = 1'b0;
    step();
    checks++;
    if (q !== 4'b0000 || toggled !== 4'b0000) begin
      errors++;
      $display("FAIL rst_over_en got q=%b tg=%b want q=0000 tg=0000", q, toggled);
    end
    rst = 1'b0; en = 1'b1; j = 4'b0000; k = 4'b0000;
    step();
    checks++;
    if (q !== 4'b0000 || toggled !== 4'b0000 || sr_err !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got q=%b tg=%b err=%b want q=0000 tg=0000 err=0", q, toggled, sr_err);
    end
  endtask

`ifdef SR2JK_TCNT_EN
  task automatic test_saturation();
    logic [1:0] exp_t [5];
    logic [3:0] exp_q;
    exp_t[0] = 2'd1; exp_t[1] = 2'd2; exp_t[2] = 2'd3; exp_t[3] = 2'd3; exp_t[4] = 2'd3;
    rst2 = 1'b1; en2 = 1'b1; j2 = 4'b0000; k2 = 4'b0000;
    step();
    checks++;
    if (tcnt2 !== 2'd0 || q2 !== 4'b0000) begin
      errors++;
      $display("FAIL sat_reset got tcnt=%0d q=%b want tcnt=0 q=0000", tcnt2, q2);
    end
    rst2 = 1'b0; j2 = 4'b1111; k2 = 4'b1111;
    exp_q = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      step();
      exp_q = ~exp_q;
      checks++;
      if (tcnt2 !== exp_t[n] || q2 !== exp_q || sr_err2 !== 1'b0) begin
        errors++;
        $display("FAIL sat edge %0d got tcnt=%0d q=%b err=%b want tcnt=%0d q=%b err=0",
                 n, tcnt2, q2, sr_err2, exp_t[n], exp_q);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; j = 4'b0000; k = 4'b0000;
`ifdef SR2JK_TCNT_EN
    rst2 = 1'b1; en2 = 1'b0; j2 = 4'b0000; k2 = 4'b0000;
`endif
    test_reset();
    test_glitch();
    test_set_clear();
    test_toggle();
    test_enable_hold();
    test_mixed();
    test_reset_mid();
`ifdef SR2JK_TCNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
